// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// ovf is present only when SERIAL_ADDSUB_OVF_EN is defined.
interface serial_addsub_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, op, a, b,
      input  busy, done, result, cout
`ifdef SERIAL_ADDSUB_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, cout
`ifdef SERIAL_ADDSUB_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial unsigned adder/subtractor: one full-adder/subtractor cell, LSB first.
// Optional signed-overflow flag enabled by SERIAL_ADDSUB_OVF_EN.
module serial_addsub #(
   parameter int unsigned WIDTH = 8
) (
   input logic            clk,
   input logic            rst,
   serial_addsub_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             op_q, op_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-2:0] acc_q, acc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q, cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             ovf_q, ovf_d;
`endif

   logic ai_c, bi_c, s_c, cnext_c;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         op_q     <= 1'b0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         acc_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         op_q     <= op_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         acc_q    <= acc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         cout_q   <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   // Next-state, serial cell and registered-output logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      op_d     = op_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      acc_d    = acc_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      cout_d   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      ovf_d    = ovf_q;
`endif

      ai_c    = a_sh_q[0];
      bi_c    = b_sh_q[0];
      s_c     = ai_c ^ bi_c ^ carry_q;
      cnext_c = op_q ? ((~ai_c & bi_c) | (carry_q & ~(ai_c ^ bi_c)))
                     : ((ai_c & bi_c)  | (carry_q & (ai_c ^ bi_c)));

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               op_d    = bus.op;
               carry_d = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_RUN;
`ifdef SERIAL_ADDSUB_OVF_EN
               a_msb_d = bus.a[WIDTH-1];
               b_msb_d = bus.b[WIDTH-1];
`endif
            end
         end
         S_RUN: begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            // New bit enters at the top; oldest bits drift toward bit 0
            acc_d   = (WIDTH-1)'({s_c, acc_q} >> 1);
            carry_d = cnext_c;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               cnt_d    = '0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               result_d = {s_c, acc_q};
               cout_d   = cnext_c;
               state_d  = S_DONE;
`ifdef SERIAL_ADDSUB_OVF_EN
               ovf_d    = op_q ? ((a_msb_q != b_msb_q) && (s_c != a_msb_q))
                               : ((a_msb_q == b_msb_q) && (s_c != a_msb_q));
`endif
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.cout   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
   assign bus.ovf    = ovf_q;
`endif
endmodule
